// File: rtl/pwm_cmp_sched.sv
// Compare-value scheduler: clamps duty targets and slews cmpA toward them at PWM period boundaries.
// Optional sticky clamp flag enabled by defining PWM_CMP_SCHED_CLAMP_ERR_EN.
module pwm_cmp_sched #(
  parameter int unsigned WIDTH  = 20,
  parameter int unsigned HRBITS = 3,
  parameter int unsigned PERIOD = 'hff
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             prd_start,
  input  logic             tgt_valid,
  input  logic [WIDTH-1:0] tgt_data,
  output logic             tgt_ready,
  input  logic [WIDTH-1:0] step,
  output logic [WIDTH-1:0] cmpA,
  output logic             busy,
  output logic             done,
  output logic             clamp_err
);

  localparam logic [WIDTH-1:0] CMP_MAX = WIDTH'(PERIOD << HRBITS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RAMP = 2'd2
  } state_t;

  state_t           state, state_d;
  logic [WIDTH-1:0] tgt_q, tgt_q_d;
  logic [WIDTH-1:0] cmp_d;
  logic             ready_d, busy_d, done_d;

  logic             accept;
  logic             tgt_clamp;
  logic [WIDTH-1:0] tgt_sat;
  logic [WIDTH:0]   diff, diff_neg;
  logic [WIDTH-1:0] mag, delta, stepped;
  logic             arrive;

  assign accept    = tgt_valid && tgt_ready;
  assign tgt_clamp = tgt_data > CMP_MAX;
  assign tgt_sat   = tgt_clamp ? CMP_MAX : tgt_data;

  // Signed distance to target in WIDTH+1 bits; step is capped to the distance so cmpA never overshoots.
  assign diff     = {1'b0, tgt_q} - {1'b0, cmpA};
  assign diff_neg = -diff;
  assign mag      = diff[WIDTH] ? diff_neg[WIDTH-1:0] : diff[WIDTH-1:0];
  assign delta    = ((step == '0) || (step >= mag)) ? mag : step;
  assign stepped  = diff[WIDTH] ? (cmpA - delta) : (cmpA + delta);
  assign arrive   = (delta == mag);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cmpA      <= '0;
      tgt_q     <= '0;
      tgt_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_d;
      cmpA      <= cmp_d;
      tgt_q     <= tgt_q_d;
      tgt_ready <= ready_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

  always_comb begin
    state_d = state;
    tgt_q_d = tgt_q;
    cmp_d   = cmpA;
    done_d  = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          tgt_q_d = tgt_sat;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (tgt_q == cmpA) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = RAMP;
        end
      end
      RAMP: begin
        // A boundary step toward the old target lands before a same-cycle retarget takes over.
        if (prd_start) begin
          cmp_d = stepped;
          if (arrive && !accept) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
        if (accept) begin
          tgt_q_d = tgt_sat;
          state_d = LOAD;
        end
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d != LOAD);
    busy_d  = (state_d != IDLE);
  end

`ifdef PWM_CMP_SCHED_CLAMP_ERR_EN
  logic clamped_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      clamped_q <= 1'b0;
      clamp_err <= 1'b0;
    end else begin
      if (accept) clamped_q <= tgt_clamp;
      if (state == LOAD && clamped_q) clamp_err <= 1'b1;
    end
  end
`else
  assign clamp_err = 1'b0;
`endif

endmodule
